// File: rtl/cpu_tx_pkg.sv
// Shared definitions for the CPU->FPGA request framing: FSM states, header layout, SOP bit, tag width.
// Also used by the FPGA-side deframer. CPU_TX_CHECKSUM_EN adds the CSUM state.
package cpu_tx_pkg;

    localparam int SOP_BIT       = 32;
    localparam int HDR_MASK_LSB  = 0;
    localparam int HDR_MASK_W    = 4;
    localparam int HDR_WRITE_BIT = 4;
    localparam int HDR_TAG_LSB   = 8;
    localparam int TAG_WIDTH     = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3
`ifdef CPU_TX_CHECKSUM_EN
        , ST_CSUM = 3'd4
`endif
    } state_t;

    function automatic logic [31:0] make_header(
        input logic [HDR_MASK_W-1:0] mask,
        input logic                  is_write,
        input logic [TAG_WIDTH-1:0]  tag
    );
        logic [31:0] h;
        h = '0;
        h[HDR_MASK_LSB +: HDR_MASK_W] = mask;
        h[HDR_WRITE_BIT]              = is_write;
        h[HDR_TAG_LSB +: TAG_WIDTH]   = tag;
        return h;
    endfunction

endpackage

// File: rtl/cpu_tx_serializer.sv
// Serializes one memory request into FIFO words: header (SOP), address, write data, and
// a trailing XOR checksum word when CPU_TX_CHECKSUM_EN is defined. Never writes while full.
module cpu_tx_serializer
    import cpu_tx_pkg::*;
#(
    parameter int WIDTH      = 33,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_mask,
    output logic [WIDTH-1:0]      fifo_data,
    output logic                  fifo_w_en,
    input  logic                  fifo_full,
    output logic                  busy,
    output state_t                fsm_state
);

    state_t                 state, state_next, tail_state;
    logic                   write_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [3:0]             mask_q;
    logic [TAG_WIDTH-1:0]   tag_q, tag_cnt;
    logic [31:0]            addr_ext, data_ext;
    logic                   accept;

    assign accept    = req_valid && req_ready;
    assign req_ready = (state == ST_IDLE) && !w_rst;
    assign busy      = (state != ST_IDLE);
    assign fifo_w_en = (state != ST_IDLE) && !fifo_full && !w_rst;
    assign fsm_state = state;

`ifdef CPU_TX_CHECKSUM_EN
    logic [31:0] csum_q;
    assign tail_state = ST_CSUM;

    // Folds every word actually written, so stalled words are counted exactly once.
    always_ff @(posedge w_clk) begin
        if (w_rst || accept) begin
            csum_q <= '0;
        end else if (fifo_w_en) begin
            csum_q <= csum_q ^ fifo_data[31:0];
        end
    end
`else
    assign tail_state = ST_IDLE;
`endif

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state   <= ST_IDLE;
            tag_cnt <= '0;
            tag_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                mask_q  <= req_mask;
                tag_q   <= tag_cnt;
                tag_cnt <= tag_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)    state_next = ST_HDR;
            ST_HDR:  if (fifo_w_en) state_next = ST_ADDR;
            ST_ADDR: if (fifo_w_en) state_next = write_q ? ST_DATA : tail_state;
            ST_DATA: if (fifo_w_en) state_next = tail_state;
`ifdef CPU_TX_CHECKSUM_EN
            ST_CSUM: if (fifo_w_en) state_next = ST_IDLE;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_ext = '0;
        addr_ext[ADDR_WIDTH-1:0] = addr_q;
        data_ext = '0;
        data_ext[DATA_WIDTH-1:0] = wdata_q;
    end

    // Output word depends only on state and captured registers, so it holds during a stall.
    always_comb begin
        fifo_data = '0;
        case (state)
            ST_HDR: begin
                fifo_data[SOP_BIT]  = 1'b1;
                fifo_data[31:0]     = make_header(mask_q, write_q, tag_q);
            end
            ST_ADDR: fifo_data[31:0] = addr_ext;
            ST_DATA: fifo_data[31:0] = data_ext;
`ifdef CPU_TX_CHECKSUM_EN
            ST_CSUM: fifo_data[31:0] = csum_q;
`endif
            default: fifo_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cpu_tx_serializer.sv
// Bench for cpu_tx_serializer: table-driven requests, FIFO stall, tag wrap, mid-packet reset.
// Expected FIFO words are queued at accept and compared as the DUT writes them.
module tb_cpu_tx_serializer;
    import cpu_tx_pkg::*;

    logic        w_clk;
    logic        w_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic [32:0] fifo_data;
    logic        fifo_w_en;
    logic        fifo_full;
    logic        busy;
    state_t      fsm_state;

    cpu_tx_serializer dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mask  (req_mask),
        .fifo_data (fifo_data),
        .fifo_w_en (fifo_w_en),
        .fifo_full (fifo_full),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [7:0]  exp_hdr_lo;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[5];
    logic [32:0] exp_q[$];
    logic [7:0]  tag_model;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [32:0] e;
        if (w_rst) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_w_en", fifo_w_en, 0);
        end else begin
            check("req_ready", req_ready, exp_q.size() == 0);
            check("busy", busy, exp_q.size() != 0);
            if (fifo_full) check("w_en_while_full", fifo_w_en, 0);
            if (fifo_w_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", fifo_data, 33'h0_dead_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_word", fifo_data, e);
                end
            end
        end
    endtask

    // One clock: outputs sampled on the falling edge, inputs changed 1 time unit after rising edge.
    task automatic step();
        @(negedge w_clk);
        monitor();
        @(posedge w_clk);
        #1;
        if (!req_valid) begin
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_mask  = 4'($urandom_range(0, 15));
            req_write = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_req(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask, input logic [7:0] hdr_lo,
                            input logic [31:0] e_addr, input logic [31:0] e_data);
        int          guard;
        logic [31:0] hdr;
        guard = 0;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!req_ready) check("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_write = write;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
        step();
        req_valid = 1'b0;
        hdr = {16'h0, tag_model, hdr_lo};
        exp_q.push_back({1'b1, hdr});
        exp_q.push_back({1'b0, e_addr});
        if (write) exp_q.push_back({1'b0, e_data});
`ifdef CPU_TX_CHECKSUM_EN
        exp_q.push_back({1'b0, hdr ^ e_addr ^ (write ? e_data : 32'h0)});
`endif
        tag_model = tag_model + 8'd1;
    endtask

    task automatic drain(input int exp_cycles);
        int cycles;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 100) begin
            step();
            cycles++;
        end
        check("drain_cycles", cycles, exp_cycles);
        exp_q.delete();
    endtask

    initial begin
        int          extra;
        logic [31:0] a;
        logic [3:0]  m;
        n_checks  = 0;
        n_fail    = 0;
        tag_model = 8'd0;
        w_rst     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mask  = '0;
        fifo_full = 1'b0;
`ifdef CPU_TX_CHECKSUM_EN
        extra = 1;
`else
        extra = 0;
`endif

        vecs[0] = '{1'b0, 32'h0000_1000, 32'h1111_2222, 4'hF, 8'h0F, 32'h0000_1000, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 4'h3, 8'h13, 32'h0000_0080, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'hABCD_0123, 4'h1, 8'h01, 32'hFFFF_FFFC, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hC, 8'h1C, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 32'h1234_5678, 32'h0000_0000, 4'h0, 8'h10, 32'h1234_5678, 32'h0000_0000};

        // Reset values
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_state", fsm_state, ST_IDLE);
        w_rst = 1'b0;
        step();

        // Table-driven packets, FIFO never full
        for (int i = 0; i < 5; i++) begin
            send_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                     vecs[i].exp_hdr_lo, vecs[i].exp_addr, vecs[i].exp_data);
            drain((vecs[i].write ? 3 : 2) + extra);
        end

        // Stall on the address word for 5 cycles
        send_req(1'b1, 32'h0000_0440, 32'hCAFE_F00D, 4'h6, 8'h16, 32'h0000_0440, 32'hCAFE_F00D);
        step();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_w_en", fifo_w_en, 0);
            check("stall_data", fifo_data, {1'b0, 32'h0000_0440});
        end
        fifo_full = 1'b0;
        drain(2 + extra);

        // Reset while in ADDR abandons the packet and clears the tag
        send_req(1'b1, 32'h0000_0900, 32'h5555_AAAA, 4'hF, 8'h1F, 32'h0000_0900, 32'h5555_AAAA);
        step();
        check("pre_rst_state", fsm_state, ST_ADDR);
        w_rst = 1'b1;
        step();
        w_rst = 1'b0;
        exp_q.delete();
        tag_model = 8'd0;
        check("post_rst_state", fsm_state, ST_IDLE);
        check("post_rst_w_en", fifo_w_en, 0);
        send_req(1'b0, 32'h0000_0004, 32'h0, 4'h2, 8'h02, 32'h0000_0004, 32'h0);
        drain(2 + extra);

        // Back-to-back reads with inputs scrambled after accept; tag wraps past 255
        for (int i = 0; i < 257; i++) begin
            a = $urandom;
            m = 4'($urandom_range(0, 15));
            send_req(1'b0, a, 32'h0, m, {4'h0, m}, a, 32'h0);
        end
        drain(2 + extra);
        check("tag_model_wrapped", tag_model, 8'd2);
        step();
        check("final_idle", fsm_state, ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
